// File: rtl/simple_uart_recv_pkg.sv
// Shared definitions for the simple UART receiver: status codes,
// receive FSM state encodings and a small shift helper.
package simple_uart_recv_pkg;

    // Status field values reported on sta_o_r
    localparam logic [1:0] SIMPLE_UART_IDLE = 2'b00;
    localparam logic [1:0] SIMPLE_UART_RECV = 2'b10;

    // Receive FSM state encodings (3 bits, unused codes fall back to idle)
    typedef enum logic [2:0] {
        RECV_STA_IDLE  = 3'd0,
        RECV_STA_START = 3'd1,
        RECV_STA_DATA  = 3'd2,
        RECV_STA_STOP  = 3'd3,
        RECV_STA_BRK   = 3'd4
    } recv_state_t;

    // LSB-first deserialisation: new bit enters at bit 7, older bits move down
    function automatic logic [7:0] shift_in_msb(input logic [7:0] sr, input logic b);
        return {b, sr[7:1]};
    endfunction

endpackage

// File: rtl/simple_uart_sync.sv
// Two-flop synchronizer for asynchronous single-bit inputs; the reset
// value is a parameter so idle-high and idle-low lines can both use it.
module simple_uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            o_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end

endmodule

// File: rtl/simple_uart_recv.sv
// 8N1 UART receiver driven by an oversampling tick. Frames are recovered
// by centre sampling and presented through a hold-until-read handshake
// with framing-error and sticky overrun flags.
module simple_uart_recv
    import simple_uart_recv_pkg::*;
#(
    parameter int OVS = 16
) (
    input  logic       clk_i_w,
    input  logic       rst_i_w,
    input  logic       en_i_w,
    input  logic       rxd_i_w,
    input  logic       read_i_w,
    output logic [7:0] rchar_o_r,
    output logic       rdy_o_r,
    output logic       ferr_o_r,
    output logic       ovr_o_r,
    output logic [1:0] sta_o_r
);

    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(OVS - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    logic          w_rxs;
    recv_state_t   r_state;
    recv_state_t   w_next_state;
    logic [TW-1:0] r_tick_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          w_start_smp;
    logic          w_data_smp;
    logic          w_stop_smp;

    simple_uart_sync #(
        .RST_VAL (1'b1)
    ) u_rxd_sync (
        .i_clk (clk_i_w),
        .i_rst (rst_i_w),
        .i_d   (rxd_i_w),
        .o_q   (w_rxs)
    );

    // State register
    always_ff @(posedge clk_i_w or posedge rst_i_w) begin
        if (rst_i_w) begin
            r_state <= RECV_STA_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; nothing moves on non-tick cycles
    always_comb begin
        w_next_state = r_state;
        if (en_i_w) begin
            case (r_state)
                RECV_STA_IDLE: begin
                    if (!w_rxs) w_next_state = RECV_STA_START;
                    else        w_next_state = RECV_STA_IDLE;
                end
                RECV_STA_START: begin
                    if (r_tick_cnt == TICK_HALF) begin
                        if (w_rxs) w_next_state = RECV_STA_IDLE;
                        else       w_next_state = RECV_STA_DATA;
                    end else begin
                        w_next_state = RECV_STA_START;
                    end
                end
                RECV_STA_DATA: begin
                    if ((r_tick_cnt == TICK_FULL) && (r_bit_cnt == 3'd7)) w_next_state = RECV_STA_STOP;
                    else                                                 w_next_state = RECV_STA_DATA;
                end
                RECV_STA_STOP: begin
                    if (r_tick_cnt == TICK_FULL) begin
                        if (w_rxs) w_next_state = RECV_STA_IDLE;
                        else       w_next_state = RECV_STA_BRK;
                    end else begin
                        w_next_state = RECV_STA_STOP;
                    end
                end
                RECV_STA_BRK: begin
                    if (w_rxs) w_next_state = RECV_STA_IDLE;
                    else       w_next_state = RECV_STA_BRK;
                end
                default: w_next_state = RECV_STA_IDLE;
            endcase
        end else begin
            w_next_state = r_state;
        end
    end

    // Per-state sample strobes used by the datapath and handshake
    always_comb begin
        w_start_smp = 1'b0;
        w_data_smp  = 1'b0;
        w_stop_smp  = 1'b0;
        if (en_i_w) begin
            case (r_state)
                RECV_STA_START: w_start_smp = (r_tick_cnt == TICK_HALF);
                RECV_STA_DATA:  w_data_smp  = (r_tick_cnt == TICK_FULL);
                RECV_STA_STOP:  w_stop_smp  = (r_tick_cnt == TICK_FULL);
                default: begin
                    w_start_smp = 1'b0;
                    w_data_smp  = 1'b0;
                    w_stop_smp  = 1'b0;
                end
            endcase
        end else begin
            w_start_smp = 1'b0;
            w_data_smp  = 1'b0;
            w_stop_smp  = 1'b0;
        end
    end

    // Tick counter, bit index and shift register, advanced on ticks only
    always_ff @(posedge clk_i_w or posedge rst_i_w) begin
        if (rst_i_w) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
        end else if (en_i_w) begin
            case (r_state)
                RECV_STA_IDLE: begin
                    r_tick_cnt <= '0;
                end
                RECV_STA_START: begin
                    if (w_start_smp) begin
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= 3'd0;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + TICK_ONE;
                    end
                end
                RECV_STA_DATA: begin
                    if (w_data_smp) begin
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        r_shift    <= shift_in_msb(r_shift, w_rxs);
                    end else begin
                        r_tick_cnt <= r_tick_cnt + TICK_ONE;
                    end
                end
                RECV_STA_STOP: begin
                    if (w_stop_smp) r_tick_cnt <= '0;
                    else            r_tick_cnt <= r_tick_cnt + TICK_ONE;
                end
                RECV_STA_BRK: begin
                    r_tick_cnt <= '0;
                end
                default: begin
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= 3'd0;
                end
            endcase
        end
    end

    // Frame-in-progress status follows the state being entered
    always_ff @(posedge clk_i_w or posedge rst_i_w) begin
        if (rst_i_w) begin
            sta_o_r <= SIMPLE_UART_IDLE;
        end else if (en_i_w) begin
            sta_o_r <= (w_next_state == RECV_STA_IDLE) ? SIMPLE_UART_IDLE : SIMPLE_UART_RECV;
        end
    end

    // Byte hand-off: completion takes priority over a same-cycle read
    always_ff @(posedge clk_i_w or posedge rst_i_w) begin
        if (rst_i_w) begin
            rchar_o_r <= 8'h00;
            rdy_o_r   <= 1'b0;
            ferr_o_r  <= 1'b0;
            ovr_o_r   <= 1'b0;
        end else if (w_stop_smp) begin
            rchar_o_r <= r_shift;
            rdy_o_r   <= 1'b1;
            ferr_o_r  <= ~w_rxs;
            ovr_o_r   <= read_i_w ? 1'b0 : (ovr_o_r | rdy_o_r);
        end else if (read_i_w) begin
            rdy_o_r   <= 1'b0;
            ferr_o_r  <= 1'b0;
            ovr_o_r   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_simple_uart_recv.sv
// Directed bench for simple_uart_recv: 8N1 frames with hand-computed
// expected bytes and flags, including glitch, break, overrun, mid-frame
// reset and a read coinciding with byte completion.
module tb_simple_uart_recv;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rxd;
    logic       rd;
    logic [7:0] rchar;
    logic       rdy;
    logic       ferr;
    logic       ovr;
    logic [1:0] sta;

    int n_checks = 0;
    int n_fail   = 0;
    int ph       = 0;
    int div      = 1;

    simple_uart_recv #(.OVS(16)) dut (
        .clk_i_w   (clk),
        .rst_i_w   (rst),
        .en_i_w    (en),
        .rxd_i_w   (rxd),
        .read_i_w  (rd),
        .rchar_o_r (rchar),
        .rdy_o_r   (rdy),
        .ferr_o_r  (ferr),
        .ovr_o_r   (ovr),
        .sta_o_r   (sta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bench step: advance to the falling edge and drive the tick
    task automatic step();
        @(negedge clk);
        en = ((ph % div) == 0);
        ph = ph + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            rxd = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        logic [9:0] fr;
        fr = {stop_v, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 16 * div; c++) begin
                step();
                rxd = fr[b];
            end
        end
    endtask

    task automatic read_pulse();
        step();
        rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; rxd = 1'b1; rd = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({rchar, rdy, ferr, ovr, sta} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_state: got rchar=%h rdy=%b ferr=%b ovr=%b sta=%b, want all zero", rchar, rdy, ferr, ovr, sta);
        end
        rst = 1'b0;
        idle(20);
    endtask

    task automatic test_basic();
        div = 1;
        send_frame(8'hA5, 1'b1);
        n_checks++;
        if (rchar !== 8'hA5 || rdy !== 1'b1 || ferr !== 1'b0 || ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_a5: got rchar=%h rdy=%b ferr=%b ovr=%b, want a5 1 0 0", rchar, rdy, ferr, ovr);
        end
        n_checks++;
        if (sta !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_sta: got %b want 00", sta);
        end
        read_pulse();
        n_checks++;
        if (rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_read: rdy got %b want 0", rdy);
        end
        idle(16);
    endtask

    task automatic test_glitch();
        div = 1;
        ph  = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            rxd = 1'b0;
        end
        step();
        rxd = 1'b1;
        n_checks++;
        if (sta !== 2'b10) begin
            n_fail++;
            $display("FAIL glitch_start: sta got %b want 10", sta);
        end
        idle(30);
        n_checks++;
        if (sta !== 2'b00 || rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_idle: got sta=%b rdy=%b, want 00 0", sta, rdy);
        end
    endtask

    task automatic test_break();
        div = 1;
        send_frame(8'h3C, 1'b0);
        for (int i = 0; i < 32; i++) step();
        n_checks++;
        if (rchar !== 8'h3C || rdy !== 1'b1 || ferr !== 1'b1 || sta !== 2'b10) begin
            n_fail++;
            $display("FAIL break_frame: got rchar=%h rdy=%b ferr=%b sta=%b, want 3c 1 1 10", rchar, rdy, ferr, sta);
        end
        read_pulse();
        for (int i = 0; i < 32; i++) step();
        n_checks++;
        if (rdy !== 1'b0 || sta !== 2'b10) begin
            n_fail++;
            $display("FAIL break_hold: got rdy=%b sta=%b, want 0 10", rdy, sta);
        end
        idle(16);
        n_checks++;
        if (sta !== 2'b00) begin
            n_fail++;
            $display("FAIL break_release: sta got %b want 00", sta);
        end
        send_frame(8'h81, 1'b1);
        n_checks++;
        if (rchar !== 8'h81 || rdy !== 1'b1 || ferr !== 1'b0) begin
            n_fail++;
            $display("FAIL break_next: got rchar=%h rdy=%b ferr=%b, want 81 1 0", rchar, rdy, ferr);
        end
    endtask

    task automatic test_back_to_back();
        div = 1;
        read_pulse();
        idle(16);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        n_checks++;
        if (rchar !== 8'h22 || rdy !== 1'b1 || ovr !== 1'b1 || ferr !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun: got rchar=%h rdy=%b ovr=%b ferr=%b, want 22 1 1 0", rchar, rdy, ovr, ferr);
        end
        read_pulse();
        n_checks++;
        if (rdy !== 1'b0 || ovr !== 1'b0 || ferr !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_read: got rdy=%b ovr=%b ferr=%b, want 0 0 0", rdy, ovr, ferr);
        end
        idle(16);
    endtask

    task automatic test_midframe_reset();
        logic [9:0] fr;
        div = 1;
        fr  = {1'b1, 8'hFF, 1'b0};
        // start bit, data bits 0..3, then half of data bit 4
        for (int k = 0; k < 16 * 5 + 8; k++) begin
            step();
            rxd = fr[k / 16];
        end
        n_checks++;
        if (sta !== 2'b10) begin
            n_fail++;
            $display("FAIL midframe_busy: sta got %b want 10", sta);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rchar, rdy, ferr, ovr, sta} !== 13'h0) begin
            n_fail++;
            $display("FAIL midframe_reset: got rchar=%h rdy=%b ferr=%b ovr=%b sta=%b, want all zero", rchar, rdy, ferr, ovr, sta);
        end
        idle(2);
        rst = 1'b0;
        idle(24);
        send_frame(8'h5A, 1'b1);
        n_checks++;
        if (rchar !== 8'h5A || rdy !== 1'b1 || ferr !== 1'b0 || ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: got rchar=%h rdy=%b ferr=%b ovr=%b, want 5a 1 0 0", rchar, rdy, ferr, ovr);
        end
    endtask

    task automatic test_read_coincident();
        logic [9:0] fr;
        div = 3;
        // leave an unread byte pending so a late read would flag overrun
        send_frame(8'h42, 1'b1);
        idle(48);
        n_checks++;
        if (rchar !== 8'h42 || rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL slow_tick_42: got rchar=%h rdy=%b, want 42 1", rchar, rdy);
        end
        fr = {1'b1, 8'h77, 1'b0};
        ph = 0;
        // with this tick phase the stop sample lands on the edge after step 459
        for (int k = 0; k < 480; k++) begin
            step();
            rxd = fr[k / 48];
            rd  = (k == 459);
            if (k == 460) begin
                n_checks++;
                if (rchar !== 8'h77 || rdy !== 1'b1 || ovr !== 1'b0 || ferr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL read_coincident: got rchar=%h rdy=%b ovr=%b ferr=%b, want 77 1 0 0", rchar, rdy, ovr, ferr);
                end
            end
        end
        rd = 1'b0;
        idle(6);
        n_checks++;
        if (rdy !== 1'b1 || rchar !== 8'h77) begin
            n_fail++;
            $display("FAIL read_coincident_hold: got rdy=%b rchar=%h, want 1 77", rdy, rchar);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_back_to_back();
        test_midframe_reset();
        test_read_coincident();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_uart_recv.md
# simple_uart_recv

Byte-oriented UART receiver that pairs with `simple_uart_send` in the peripherals tree. It recovers 8N1 frames from an asynchronous `rxd` line using an oversampling tick supplied by the shared baud generator. It presents each received byte through a hold-until-read handshake, with framing and overrun flags, so the LC-3 bus wrapper can poll it alongside the transmitter.

## Interface
- `OVS`, 16: oversample ticks per bit; even, ≥4.
- `clk_i_w` input 1: single system clock; all logic on its rising edge.
- `rst_i_w` input 1: reset; asynchronous, active-high.
- `en_i_w` input 1: oversample tick, one-cycle pulse at OVS × baud. The FSM and sample counter advance only on tick cycles.
- `rxd_i_w` input 1: serial input; asynchronous, idle high.
- `read_i_w` input 1: consumer acknowledge; acts in any cycle, tick not required.
- `rchar_o_r` output 8: last received byte. Reset 8'h00.
- `rdy_o_r` output 1: byte available. Reset 0.
- `ferr_o_r` output 1: stop bit sampled low for the byte in `rchar_o_r`. Reset 0.
- `ovr_o_r` output 1: a byte completed while `rdy_o_r` was already 1. Sticky. Reset 0.
- `sta_o_r` output 2: bit1 = frame in progress (`simple_uart_recv`), bit0 = 0. Reset `simple_uart_idle`.

## Operation
- Input conditioning: `rxd_i_w` passes through a 2-flop synchronizer, reset value 1. All decisions use the synchronized signal `rxs`.
- Counters:
  - `tick_cnt` is a 4-bit counter (width clog2(OVS)); it counts tick cycles within a bit.
  - `bit_cnt` is 3 bits and indexes the data bit.
- FSM states:
  - IDLE: on a tick with `rxs`=0, clear `tick_cnt`, go to START, set `sta_o_r[1]`.
  - START: on a tick where `tick_cnt`=OVS/2−1, sample `rxs`.
    - If `rxs`=0: go to DATA and clear `tick_cnt` and `bit_cnt`.
    - If `rxs`=1: it was a glitch; go to IDLE and clear `sta_o_r[1]`.
  - DATA: on a tick where `tick_cnt`=OVS−1, shift `rxs` into bit 7 of the shift register (LSB first).
    - After the 8th sample (`bit_cnt`=7), go to STOP.
  - STOP: on a tick where `tick_cnt`=OVS−1, sample `rxs` and load `rchar_o_r` from the shift register.
    - Set `rdy_o_r`=1 and set `ferr_o_r` to the inverse of the sampled stop bit.
    - If `rdy_o_r` was already 1, set `ovr_o_r`=1; the new byte still overwrites `rchar_o_r`.
    - Next state: IDLE if the stop bit was 1, else BRK.
  - BRK: wait until a tick with `rxs`=1, then go to IDLE.
  - `sta_o_r[1]` clears on leaving STOP→IDLE or BRK→IDLE.
- Handshake:
  - `read_i_w`=1 clears `rdy_o_r`, `ferr_o_r` and `ovr_o_r` next clock.
  - If `read_i_w` and a byte completion occur in the same cycle, completion wins: `rdy_o_r`=1, flags from the new byte, `ovr_o_r` cleared.
- `en_i_w`=0 freezes all FSM and counter state. The synchronizer and the handshake logic keep running.
- Unencoded state values fall to IDLE.

## Timing
- Start bit is validated OVS/2 ticks after the falling edge is detected. Each data and stop sample is then taken OVS ticks apart, i.e. at bit centres.
- `rdy_o_r` rises one clock after the stop-sample tick. Latency from the falling edge on the pin is about 9.5 bit times + 3 clocks, including the synchronizer.
- Back-to-back frames need no idle gap: IDLE detects the next start bit on the first tick after STOP.
- Reset mid-frame:
  - All outputs return to reset values immediately (asynchronous).
  - After release, the FSM waits in IDLE for a new low level, so a partial frame may be mis-framed once; this is accepted.
- `read_i_w` held high continuously leaves `rdy_o_r` as a one-cycle pulse per byte.

## Structure
- Add to shared `simple_uart_def.v`:
  - `` `simple_uart_recv `` = 2'b10.
  - Receive state encodings `` `recv_sta_idle/start/data/stop/brk ``, 3 bits.
- One sub-module, `simple_uart_sync`: a 2-flop synchronizer with a reset-value parameter. Reuse it for any later asynchronous inputs.
- Everything else, including FSM, counters, shift register and handshake, is flat in `simple_uart_recv`.

## Test plan
- OVS=16, tick every clock. Drive 0xA5 8N1 at 16 clocks/bit → `rchar_o_r`=8'hA5, `rdy_o_r`=1, `ferr_o_r`=0. Then pulse `read_i_w` → `rdy_o_r`=0.
- Low glitch of 5 ticks on an idle line → FSM returns to IDLE, `rdy_o_r` stays 0, `sta_o_r` back to 2'b00.
- Send 0x3C with the stop bit driven 0, and hold the line low for 2 more bits → `rchar_o_r`=8'h3C, `ferr_o_r`=1. No new frame starts until `rxd` goes high, and the next byte 0x81 is then received correctly.
- Send 0x11 then 0x22 back-to-back without reading → `rchar_o_r`=8'h22, `ovr_o_r`=1. Then `read_i_w` → all flags 0.
- Assert `rst_i_w` during data bit 4 of 0xFF → outputs reset in the same cycle. Then send 0x5A after ≥1 idle bit → 8'h5A received.
- Tick every 3rd clock, `read_i_w` coincident with the stop-sample cycle of byte 0x77 → `rdy_o_r`=1, `ovr_o_r`=0, `rchar_o_r`=8'h77.
